mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the datapath width.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port start_i, input, 1, a mul/div instruction is valid in EX.
REQ-005 SHALL have port op_i, input, 3, RV M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port word_i, input, 1, *W variant: 32-bit operation with sign-extended result.
REQ-007 SHALL have ports src1_i and src2_i, input, XLEN each, operands.
REQ-008 SHALL have port flush_i, input, 1, EX stage flush from the pipeline controller.
REQ-009 SHALL have port advance_i, input, 1, asserted when the EX/MEM register captures this cycle.
REQ-010 SHALL have port stall_req_o, output, 1, mul/div stall request to the pipeline controller.
REQ-011 SHALL have port result_o, output, XLEN, result.
REQ-012 SHALL have port result_valid_o, output, 1, result_o is valid.

Function
REQ-013 SHALL implement states IDLE, BUSY and DONE.
REQ-014 SHALL move IDLE->BUSY when start_i=1 and flush_i=0, latching op_i, word_i, src1_i and src2_i; operand changes afterwards SHALL be ignored until the next IDLE.
REQ-015 SHALL, in BUSY, perform one radix-2 iteration per cycle: shift-add for multiply, restoring for divide, on operand magnitudes, with sign fix-up in the final cycle.
REQ-016 SHALL use an iteration count of XLEN, or 32 when word_i=1; BUSY->DONE follows the last iteration, so result_valid_o first rises XLEN+1 (or 33) cycles after the start cycle.
REQ-017 SHALL treat a divisor of zero as a special case completing IDLE->DONE in 1 cycle: quotient all ones, remainder = dividend.
REQ-018 SHALL treat signed overflow (most-negative / -1) as a special case completing in 1 cycle: quotient = dividend, remainder = 0.
REQ-019 SHALL, for word_i=1, use src[31:0] only and produce a 32-bit result sign-extended to XLEN; MULH* with word_i=1 SHALL be unsupported and behave as MUL.
REQ-020 SHALL return the low XLEN bits of the 2*XLEN product for MUL and the high XLEN bits for MULH, MULHSU and MULHU.
REQ-021 SHALL, in DONE, hold result_valid_o=1 and result_o stable until advance_i=1, then go to IDLE, so a longer external stall never re-triggers the operation.
REQ-022 SHALL drive stall_req_o = start_i AND (state != DONE), combinationally.
REQ-023 SHALL, when flush_i=1 in any state, go to IDLE on the next edge with result_valid_o=0; flush_i SHALL win over start_i in the same cycle.
REQ-024 SHALL ignore start_i while in BUSY or DONE.

Reset
REQ-025 SHALL, while rst=1, force IDLE, iteration counter 0, result_o=0, result_valid_o=0 and stall_req_o=start_i.
REQ-026 SHALL abort any operation in progress when rst is asserted mid-BUSY, with no result produced.

Configuration
REQ-027 SHALL, with FAST_MUL_EN defined, compute multiplies with a single registered full product (IDLE->BUSY->DONE, result_valid_o 2 cycles after start).
REQ-028 SHALL, with FAST_MUL_EN undefined, compute multiplies iteratively per REQ-016; divide SHALL be iterative in both cases.

Structure
REQ-029 SHALL place funct3 op encodings, the state enum and XLEN in a shared package.
REQ-030 SHALL place the divide iteration datapath in sub-module mdu_div_iter, with the FSM and multiplier in mul_div_unit.

Verification
REQ-031 SHALL cover: XLEN=64, DIVU 100/7 -> result 14 at cycle 65, stall_req_o high cycles 0..64, low on cycle 65.
REQ-032 SHALL cover: REM -7/2 -> result 0xFFFF_FFFF_FFFF_FFFF (-1); DIV -7/2 -> -3.
REQ-033 SHALL cover: DIV x/0 -> 0xFFFF_FFFF_FFFF_FFFF after 1 cycle; DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000, REM -> 0.
REQ-034 SHALL cover: MULHU 0xFFFF_FFFF_FFFF_FFFF * 2 -> 1; MULW 0x7FFF_FFFF * 2 -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-035 SHALL cover: flush_i at BUSY cycle 10 -> IDLE next cycle, result_valid_o never asserted; a new start 1 cycle later -> correct result.
REQ-036 SHALL cover: DONE with advance_i=0 for 5 cycles -> result_valid_o held for 5 cycles, no restart; advance_i=1 -> IDLE.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV64 M-extension multiply/divide unit:
// datapath width, funct3 op encodings and the FSM state type.
package mul_div_unit_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// Restoring radix-2 divider datapath on unsigned magnitudes; one quotient bit
// per step. The caller applies sign fix-up to quo_next/rem_next on the last step.
module mdu_div_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            load,
  input  logic            step,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] sub;
  logic            fits;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = (shifted >= {1'b0, dsr_q});
    sub     = shifted[XLEN-1:0] - dsr_q;
    if (fits) begin
      rem_next = sub;
      quo_next = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  // Word divides run 32 steps, so the dividend is pre-aligned to the top bits.
  always_ff @(posedge clk) begin
    if (load) begin
      quo_q <= word ? (dividend << (XLEN - 32)) : dividend;
      rem_q <= '0;
      dsr_q <= divisor;
    end else if (step) begin
      quo_q <= quo_next;
      rem_q <= rem_next;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV64 M-extension multiply/divide unit with pipeline stall handshake.
// Define FAST_MUL_EN for a single-cycle full-product multiplier.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = mul_div_unit_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  input  logic            advance_i,
  output logic            stall_req_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o
);

  localparam int CNT_W = $clog2(XLEN);

  mdu_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      op_q;
  logic            word_q;
  logic            neg_a_q;
  logic            neg_b_q;
  logic [XLEN-1:0] prod_hi;
  logic [XLEN-1:0] prod_lo;
  logic [XLEN-1:0] mcand;

  logic            is_div;
  logic [2:0]      op_eff;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] low_mask;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] src1_res;
  logic [XLEN-1:0] most_neg;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;
  logic            accept;

  // Word-sized MULH* degrade to MUL; all operands become unsigned magnitudes.
  always_comb begin
    is_div   = op_i[2];
    op_eff   = (word_i && !is_div) ? OP_MUL : op_i;
    a_signed = (op_eff == OP_MULH) || (op_eff == OP_MULHSU) ||
               (op_eff == OP_DIV)  || (op_eff == OP_REM);
    b_signed = (op_eff == OP_MULH) || (op_eff == OP_DIV) || (op_eff == OP_REM);
    a_neg    = a_signed && (word_i ? src1_i[31] : src1_i[XLEN-1]);
    b_neg    = b_signed && (word_i ? src2_i[31] : src2_i[XLEN-1]);
    low_mask = word_i ? {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF} : {XLEN{1'b1}};
    a_mag    = (a_neg ? -src1_i : src1_i) & low_mask;
    b_mag    = (b_neg ? -src2_i : src2_i) & low_mask;
    src1_res = word_i ? {{(XLEN-32){src1_i[31]}}, src1_i[31:0]} : src1_i;
    most_neg = {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_div && ((src2_i & low_mask) == '0);
    div_ovf  = is_div && !op_i[0] &&
               (word_i ? (src1_i[31:0] == 32'h8000_0000 && src2_i[31:0] == 32'hFFFF_FFFF)
                       : (src1_i == most_neg && src2_i == {XLEN{1'b1}}));
    if (op_i[1]) special_res = div_zero ? src1_res : '0;
    else         special_res = div_zero ? {XLEN{1'b1}} : src1_res;
    accept   = (state == IDLE) && start_i && !flush_i;
  end

  logic            div_step;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] rem_next;

  assign div_step = (state == BUSY) && op_q[2];

  mdu_div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk      (clk),
    .load     (accept),
    .step     (div_step),
    .word     (word_i),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   div_result;
  logic [2*XLEN-1:0] mul_full;
  logic [2*XLEN-1:0] mul_signed;
  logic [31:0]       mul_low;
  logic [XLEN-1:0]   mul_result;
  logic              mul_last;
  logic [CNT_W-1:0]  last_cnt;
  logic              busy_last;
`ifndef FAST_MUL_EN
  logic [XLEN:0]     mul_sum;
`endif

  // Sign fix-up is applied to the value produced by the final iteration.
  always_comb begin
    quo_fix    = (neg_a_q ^ neg_b_q) ? -quo_next : quo_next;
    rem_fix    = neg_a_q ? -rem_next : rem_next;
    div_sel    = op_q[1] ? rem_fix : quo_fix;
    div_result = word_q ? {{(XLEN-32){div_sel[31]}}, div_sel[31:0]} : div_sel;
    last_cnt   = word_q ? CNT_W'(31) : CNT_W'(XLEN - 1);
`ifdef FAST_MUL_EN
    mul_full   = {{XLEN{1'b0}}, mcand} * {{XLEN{1'b0}}, prod_lo};
    mul_low    = mul_full[31:0];
    mul_last   = 1'b1;
`else
    mul_sum    = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
    mul_full   = {mul_sum, prod_lo[XLEN-1:1]};
    mul_low    = mul_full[XLEN-32 +: 32];
    mul_last   = (cnt == last_cnt);
`endif
    mul_signed = (neg_a_q ^ neg_b_q) ? -mul_full : mul_full;
    if (word_q)                mul_result = {{(XLEN-32){mul_low[31]}}, mul_low};
    else if (op_q == OP_MUL)   mul_result = mul_signed[XLEN-1:0];
    else                       mul_result = mul_signed[2*XLEN-1:XLEN];
    busy_last  = op_q[2] ? (cnt == last_cnt) : mul_last;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mcand   <= a_mag;
      prod_lo <= b_mag;
      prod_hi <= '0;
    end else if ((state == BUSY) && !op_q[2]) begin
      prod_hi <= mul_full[2*XLEN-1:XLEN];
      prod_lo <= mul_full[XLEN-1:0];
    end
  end

  // DONE holds the result until the pipeline captures it, so a stalled start never re-fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      op_q           <= OP_MUL;
      word_q         <= 1'b0;
      neg_a_q        <= 1'b0;
      neg_b_q        <= 1'b0;
    end else if (flush_i) begin
      state          <= IDLE;
      cnt            <= '0;
      result_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            op_q    <= op_eff;
            word_q  <= word_i;
            neg_a_q <= a_neg;
            neg_b_q <= b_neg;
            cnt     <= '0;
            if (div_zero || div_ovf) begin
              result_o       <= special_res;
              result_valid_o <= 1'b1;
              state          <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (busy_last) begin
            result_o       <= op_q[2] ? div_result : mul_result;
            result_valid_o <= 1'b1;
            cnt            <= '0;
            state          <= DONE;
          end
        end
        DONE: begin
          if (advance_i) begin
            result_valid_o <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_req_o = start_i && (rst || (state != DONE));

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard testbench for mul_div_unit: expected results are queued at issue
// and popped when result_valid_o rises. Honours FAST_MUL_EN for multiply latency.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [2:0]   op_i;
  logic         word_i;
  logic [W-1:0] src1_i;
  logic [W-1:0] src2_i;
  logic         flush_i;
  logic         advance_i;
  logic         stall_req_o;
  logic [W-1:0] result_o;
  logic         result_valid_o;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] expQ[$];

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .op_i           (op_i),
    .word_i         (word_i),
    .src1_i         (src1_i),
    .src2_i         (src2_i),
    .flush_i        (flush_i),
    .advance_i      (advance_i),
    .stall_req_o    (stall_req_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] refModel(input logic [2:0] op, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, prod;
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  sa32, sb32;
    logic [31:0]         r32;
    logic [63:0]         r;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0];
    if (w) begin
      if (!op[2]) r32 = a[31:0] * b[31:0];
      else if (b[31:0] == 32'h0) r32 = op[1] ? a[31:0] : 32'hFFFF_FFFF;
      else if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
        r32 = op[1] ? 32'h0 : 32'h8000_0000;
      else begin
        case (op)
          OP_DIV:  r32 = sa32 / sb32;
          OP_DIVU: r32 = a[31:0] / b[31:0];
          OP_REM:  r32 = sa32 % sb32;
          default: r32 = a[31:0] % b[31:0];
        endcase
      end
      return {{32{r32[31]}}, r32};
    end
    if (op == OP_MUL) r = a * b;
    else if (!op[2]) begin
      if (op == OP_MULHU) pa = {64'h0, a}; else pa = sa;
      if (op == OP_MULH)  pb = sb;         else pb = {64'h0, b};
      prod = pa * pb;
      r = prod[127:64];
    end
    else if (b == 64'h0) r = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
      r = op[1] ? 64'h0 : a;
    else begin
      case (op)
        OP_DIV:  r = sa / sb;
        OP_DIVU: r = a / b;
        OP_REM:  r = sa % sb;
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int expLatency(input logic [2:0] op, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    logic div0, ovf;
    if (!op[2]) begin
`ifdef FAST_MUL_EN
      return 2;
`else
      return w ? 33 : 65;
`endif
    end
    div0 = w ? (b[31:0] == 32'h0) : (b == 64'h0);
    ovf  = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (div0 || ovf) return 1;
    return w ? 33 : 65;
  endfunction

  // Called at posedge+1; start_i stays high like a stalled EX stage until advance.
  task automatic applyStimulus(input logic [2:0] op, input logic w,
                               input logic [63:0] a, input logic [63:0] b, input int hold);
    int         lat;
    bit         seen;
    bit         stallOk;
    logic [63:0] expv;
    expQ.push_back(refModel(op, w, a, b));
    lat = expLatency(op, w, a, b);
    start_i = 1'b1; op_i = op; word_i = w; src1_i = a; src2_i = b; advance_i = 1'b0;
    seen = 1'b0; stallOk = 1'b1;
    for (int k = 0; k <= 200 && !seen; k++) begin
      @(negedge clk);
      if (result_valid_o) begin
        seen = 1'b1;
        expv = expQ.pop_front();
        checkOutput("latency", 64'(k), 64'(lat));
        checkOutput("stall_busy", {63'h0, stallOk}, 64'h1);
        checkOutput("stall_done", {63'h0, stall_req_o}, 64'h0);
        checkOutput("result", result_o, expv);
        for (int h = 0; h < hold; h++) begin
          @(posedge clk); #1;
          src1_i = {$urandom, $urandom};
          @(negedge clk);
          checkOutput("hold_valid", {63'h0, result_valid_o}, 64'h1);
          checkOutput("hold_result", result_o, expv);
          checkOutput("hold_stall", {63'h0, stall_req_o}, 64'h0);
        end
        advance_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; advance_i = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_adv", {63'h0, result_valid_o}, 64'h0);
        @(posedge clk); #1;
      end else begin
        if (!stall_req_o) stallOk = 1'b0;
        @(posedge clk); #1;
        if (k == 0) begin
          op_i = 3'($urandom_range(0, 7)); word_i = 1'($urandom);
          src1_i = {$urandom, $urandom}; src2_i = {$urandom, $urandom};
        end
      end
    end
    if (!seen) begin
      checkOutput("timeout", 64'h0, 64'h1);
      void'(expQ.pop_front());
      start_i = 1'b0; flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
    end
  endtask

  bit sawValid;

  initial begin
    rst = 1'b1; start_i = 1'b1; op_i = OP_DIVU; word_i = 1'b0;
    src1_i = 64'd100; src2_i = 64'd7; flush_i = 1'b0; advance_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall_start", {63'h0, stall_req_o}, 64'h1);
    checkOutput("rst_valid", {63'h0, result_valid_o}, 64'h0);
    checkOutput("rst_result", result_o, 64'h0);
    start_i = 1'b0;
    #1;
    checkOutput("rst_stall_nostart", {63'h0, stall_req_o}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed operations");
    applyStimulus(OP_DIVU, 1'b0, 64'd100, 64'd7, 0);
    applyStimulus(OP_REM,  1'b0, -64'sd7, 64'd2, 0);
    applyStimulus(OP_DIV,  1'b0, -64'sd7, 64'd2, 0);
    applyStimulus(OP_DIV,  1'b0, 64'd1234, 64'd0, 0);
    applyStimulus(OP_REMU, 1'b0, 64'd1234, 64'd0, 0);
    applyStimulus(OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    applyStimulus(OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    applyStimulus(OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
    applyStimulus(OP_MUL,  1'b1, 64'h7FFF_FFFF, 64'd2, 0);
    applyStimulus(OP_MULH, 1'b0, -64'sd3, 64'd5, 0);
    applyStimulus(OP_MULHSU, 1'b0, -64'sd1, 64'd3, 0);
    applyStimulus(OP_MUL,  1'b0, -64'sd3, 64'd5, 0);
    applyStimulus(OP_DIV,  1'b1, 64'hFFFF_FFF9, 64'd2, 0);
    applyStimulus(OP_REMU, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h10, 0);
    applyStimulus(OP_MULH, 1'b1, 64'h0001_0000, 64'h0001_0000, 0);

    $display("[TB] DONE hold with advance low");
    applyStimulus(OP_DIV, 1'b0, 64'd50, 64'd5, 5);

    $display("[TB] flush during BUSY");
    start_i = 1'b1; op_i = OP_DIVU; word_i = 1'b0; src1_i = 64'd1000; src2_i = 64'd3;
    sawValid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (result_valid_o) sawValid = 1'b1;
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    if (result_valid_o) sawValid = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    if (result_valid_o) sawValid = 1'b1;
    checkOutput("flush_no_valid", {63'h0, sawValid}, 64'h0);
    @(posedge clk); #1;
    applyStimulus(OP_DIVU, 1'b0, 64'd1000, 64'd3, 0);

    $display("[TB] flush beats start in IDLE");
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_DIV; word_i = 1'b0; src1_i = 64'd5; src2_i = 64'd0;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    checkOutput("flush_wins_start", {63'h0, result_valid_o}, 64'h0);
    @(posedge clk); #1;

    $display("[TB] reset during BUSY");
    start_i = 1'b1; op_i = OP_DIVU; word_i = 1'b0; src1_i = 64'd77; src2_i = 64'd5;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_abort_result", result_o, 64'h0);
    sawValid = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (result_valid_o) sawValid = 1'b1;
    end
    checkOutput("rst_abort_no_valid", {63'h0, sawValid}, 64'h0);
    @(posedge clk); #1;

    $display("[TB] random operations");
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  rop;
      logic        rw;
      logic [63:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      rw  = 1'($urandom);
      ra  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = 64'($urandom_range(0, 9));
        1:       rb = -64'($urandom_range(1, 9));
        default: rb = {$urandom, $urandom};
      endcase
      applyStimulus(rop, rw, ra, rb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
